// File: rtl/m_demux_dispatch_pkg.sv
// ============================================================================
// Module : m_demux_dispatch_pkg
// Brief  : Shared state encoding and drop-counter constants for the dispatcher.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package m_demux_dispatch_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam int                  C_DROP_W   = 8;
    localparam logic [C_DROP_W-1:0] C_DROP_MAX = 8'hFF;

    function automatic logic [C_DROP_W-1:0] f_sat_inc(input logic [C_DROP_W-1:0] i_v);
        return (i_v == C_DROP_MAX) ? i_v : i_v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_demux.sv
// ============================================================================
// Module : m_demux
// Brief  : 1-to-2**SEL_W demultiplexer; routes a single bit to the selected line.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module m_demux #(
    parameter int SEL_W = 2
) (
    input  logic                i_in,
    input  logic [SEL_W-1:0]    i_sel,
    output logic [2**SEL_W-1:0] o_out
);

    always_comb begin
        o_out        = '0;
        o_out[i_sel] = i_in;
    end

endmodule

`default_nettype wire

// File: rtl/m_demux_dispatch.sv
// ============================================================================
// Module : m_demux_dispatch
// Brief  : Captures one word, steers it to a fixed or round-robin line, drops on timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module m_demux_dispatch
    import m_demux_dispatch_pkg::*;
#(
    parameter int WORD    = 8,
    parameter int DEMUX   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [WORD-1:0]     in_data,
    input  logic [DEMUX-1:0]    in_dest,
    output logic                in_ready,
    input  logic                rr_mode,
    output logic [DEMUX-1:0]    select,
    output logic [WORD-1:0]     out_data,
    output logic [2**DEMUX-1:0] out_valid,
    input  logic [2**DEMUX-1:0] line_ready,
    input  logic                clear_err,
    output logic                err,
    output logic [C_DROP_W-1:0] drop_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    state_e              r_state;
    state_e              w_next;
    logic [DEMUX-1:0]    r_sel;
    logic [DEMUX-1:0]    r_rr_ptr;
    logic [WORD-1:0]     r_data;
    logic                r_rr;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_err;
    logic [C_DROP_W-1:0] r_drop_cnt;

    logic w_accept;
    logic w_drive;
    logic w_hit;
    logic w_expire;
    logic w_done;

    assign w_drive  = (r_state == ST_DRIVE);
    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_hit    = w_drive && line_ready[r_sel];
    // Delivery in the last permitted cycle beats the timeout.
    assign w_expire = w_drive && !line_ready[r_sel] && (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_done   = w_hit || w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (w_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The round-robin decision is latched with the word so a later rr_mode change cannot alter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_sel    <= '0;
            r_rr     <= 1'b0;
            r_rr_ptr <= '0;
            r_wait   <= '0;
        end else begin
            if (w_accept) begin
                r_data <= in_data;
                r_sel  <= rr_mode ? r_rr_ptr : in_dest;
                r_rr   <= rr_mode;
                r_wait <= '0;
            end else if (w_drive && !w_done) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_done && r_rr) begin
                r_rr_ptr <= r_rr_ptr + DEMUX'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_err) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_expire) begin
            r_err      <= 1'b1;
            r_drop_cnt <= f_sat_inc(r_drop_cnt);
        end
    end

    m_demux #(
        .SEL_W (DEMUX)
    ) u_demux (
        .i_in  (w_drive),
        .i_sel (r_sel),
        .o_out (out_valid)
    );

    assign select   = r_sel;
    assign out_data = r_data;
    assign err      = r_err;
    assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_m_demux_dispatch.sv
// ============================================================================
// Module : tb_m_demux_dispatch
// Brief  : Directed bench with a transaction-level reference model of the dispatcher.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_m_demux_dispatch;

    localparam int WORD    = 8;
    localparam int DEMUX   = 2;
    localparam int TIMEOUT = 16;
    localparam int LINES   = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WORD-1:0]  in_data;
    logic [DEMUX-1:0] in_dest;
    logic             in_ready;
    logic             rr_mode;
    logic [DEMUX-1:0] select;
    logic [WORD-1:0]  out_data;
    logic [LINES-1:0] out_valid;
    logic [LINES-1:0] line_ready;
    logic             clear_err;
    logic             err;
    logic [7:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    m_demux_dispatch #(
        .WORD    (WORD),
        .DEMUX   (DEMUX),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_ready   (in_ready),
        .rr_mode    (rr_mode),
        .select     (select),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .line_ready (line_ready),
        .clear_err  (clear_err),
        .err        (err),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is either in flight or not; it leaves on delivery or after TIMEOUT misses.
    bit         m_busy;
    int         m_dest;
    int         m_ptr;
    int         m_waited;
    int         m_drops;
    bit         m_err;
    bit         m_rr;
    logic [7:0] m_data;

    task automatic m_reset();
        m_busy = 0; m_dest = 0; m_ptr = 0; m_waited = 0;
        m_drops = 0; m_err = 0; m_rr = 0; m_data = 8'h00;
    endtask

    task automatic m_step();
        if (!m_busy) begin
            if (in_valid) begin
                m_busy   = 1;
                m_data   = in_data;
                m_dest   = rr_mode ? m_ptr : int'(in_dest);
                m_rr     = rr_mode;
                m_waited = 0;
            end
        end else if (line_ready[m_dest]) begin
            m_busy = 0;
            if (m_rr) m_ptr = (m_ptr + 1) % LINES;
        end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
                m_busy = 0;
                if (m_rr) m_ptr = (m_ptr + 1) % LINES;
                m_err = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        if (clear_err) begin
            m_err   = 0;
            m_drops = 0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) m_reset();
            else        m_step();
            #1;
            if (rst_n) begin
                chk("in_ready", 32'(in_ready), 32'(!m_busy));
                chk("out_valid", 32'(out_valid), m_busy ? (32'd1 << m_dest) : 32'd0);
                if (m_busy) begin
                    chk("select", 32'(select), 32'(m_dest));
                    chk("out_data", 32'(out_data), 32'(m_data));
                end
                chk("err", 32'(err), 32'(m_err));
                chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
            end
        end
    end

    int n;
    int acc;
    int sels[$];
    logic [DEMUX-1:0] exp_sel [5];

    initial begin
        rst_n = 0; in_valid = 0; in_data = '0; in_dest = '0;
        rr_mode = 0; line_ready = '0; clear_err = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_select", 32'(select), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Fixed destination delivery
        in_valid = 1; in_data = 8'hA5; in_dest = 2'd2; line_ready = 4'b0100;
        @(negedge clk);
        in_valid = 0;
        chk("fix_out_valid", 32'(out_valid), 32'h4);
        chk("fix_select", 32'(select), 32'h2);
        chk("fix_out_data", 32'(out_data), 32'hA5);
        chk("fix_in_ready_busy", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("fix_back_idle", 32'(in_ready), 32'h1);
        chk("fix_valid_low", 32'(out_valid), 32'h0);

        // Round-robin back-to-back with wrap
        rr_mode = 1; line_ready = 4'hF; in_valid = 1; acc = 0;
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2; exp_sel[3] = 2'd3; exp_sel[4] = 2'd0;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'(8'h10 + k);
            if (in_ready) acc++;
            @(negedge clk);
            if (out_valid != 0) sels.push_back(int'(select));
        end
        in_valid = 0;
        chk("rr_accepts", 32'(acc), 32'd5);
        chk("rr_count", 32'(sels.size()), 32'd5);
        for (int k = 0; k < 5 && k < sels.size(); k++)
            chk("rr_select", 32'(sels[k]), 32'(exp_sel[k]));

        // rr_mode flip while a round-robin word is in flight
        line_ready = 4'h0; in_valid = 1; in_dest = 2'd3; in_data = 8'h3C;
        @(negedge clk);
        in_valid = 0;
        chk("flip_select", 32'(select), 32'h1);
        rr_mode = 0; in_dest = 2'd0;
        @(negedge clk);
        line_ready = 4'hF;
        @(negedge clk);
        rr_mode = 1; in_valid = 1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 0;
        chk("flip_next_select", 32'(select), 32'h2);
        @(negedge clk);
        rr_mode = 0;

        // Timeout drop then clear
        line_ready = 4'h0; in_valid = 1; in_dest = 2'd1; in_data = 8'h77; n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            in_valid = 0;
            if (out_valid != 0) n++;
            else break;
        end
        chk("to_drive_cycles", 32'(n), 32'd16);
        chk("to_err", 32'(err), 32'h1);
        chk("to_drop_cnt", 32'(drop_cnt), 32'h1);
        chk("to_idle", 32'(in_ready), 32'h1);
        clear_err = 1;
        @(negedge clk);
        clear_err = 0;
        chk("clr_err", 32'(err), 32'h0);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'h0);

        // Ready arrives in the final allowed cycle
        in_valid = 1; in_data = 8'h99; in_dest = 2'd1; n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            in_valid = 0;
            if (out_valid != 0) begin
                n++;
                if (n == 16) line_ready = 4'b0010;
            end else break;
        end
        line_ready = 4'h0;
        chk("late_drive_cycles", 32'(n), 32'd16);
        chk("late_err", 32'(err), 32'h0);
        chk("late_drop_cnt", 32'(drop_cnt), 32'h0);

        // Clear coinciding with a drop
        in_valid = 1; in_data = 8'h42; in_dest = 2'd3; n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            in_valid = 0;
            clear_err = 0;
            if (out_valid != 0) begin
                n++;
                if (n == 16) clear_err = 1;
            end else break;
        end
        clear_err = 0;
        chk("clrdrop_cycles", 32'(n), 32'd16);
        chk("clrdrop_err", 32'(err), 32'h0);
        chk("clrdrop_cnt", 32'(drop_cnt), 32'h0);

        // Saturation of the drop counter
        rr_mode = 1; line_ready = 4'h0; in_valid = 1;
        for (int k = 0; k < 300 * 17; k++) begin
            in_data = 8'(k);
            @(negedge clk);
        end
        in_valid = 0;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("sat_idle_reached", 32'(in_ready), 32'h1);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        chk("sat_err", 32'(err), 32'h1);

        // Reset mid-DRIVE
        rr_mode = 0; in_valid = 1; in_dest = 2'd0; in_data = 8'hE1;
        @(negedge clk);
        in_valid = 0;
        chk("mid_busy", 32'(out_valid), 32'h1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_out_data", 32'(out_data), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'h1);
        chk("rel_drop_cnt", 32'(drop_cnt), 32'h0);

        line_ready = 4'hF; in_valid = 1; in_dest = 2'd3; in_data = 8'hC3;
        @(negedge clk);
        in_valid = 0;
        chk("rel_select", 32'(select), 32'h3);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/m_demux_dispatch.md
M_DEMUX_DISPATCH -- requirements
Module: m_demux_dispatch

Interface
REQ-001 Parameter WORD, default 8: data word width in bits.
REQ-002 Parameter DEMUX, default 2: select width; the number of lines is 2**DEMUX.
REQ-003 Parameter TIMEOUT, default 16: maximum number of DRIVE cycles to wait for line_ready (minimum 2).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  a source word is offered.
REQ-007 in_data  input  WORD  the source word.
REQ-008 in_dest  input  DEMUX  destination line index (used when rr_mode=0).
REQ-009 in_ready  output  1  the dispatcher can accept a word.
REQ-010 rr_mode  input  1  when 1, ignore in_dest and use the round-robin pointer.
REQ-011 select  output  DEMUX  steering code for the downstream demux.
REQ-012 out_data  output  WORD  the held word, shared by all lines.
REQ-013 out_valid  output  2**DEMUX  one-hot valid for the selected line.
REQ-014 line_ready  input  2**DEMUX  per-line acceptance.
REQ-015 clear_err  input  1  synchronous clear of err and drop_cnt.
REQ-016 err  output  1  sticky flag: a timeout drop has occurred.
REQ-017 drop_cnt  output  8  count of dropped words; saturates at 255.

Function
REQ-018 FSM states: IDLE and DRIVE.
REQ-019 IDLE: in_ready=1 and out_valid=0; when in_valid=1, capture in_data, capture the destination (rr_ptr if rr_mode=1, else in_dest), and move to DRIVE on the next edge.
REQ-020 DRIVE: in_ready=0; out_valid has only bit [select] set; select and out_data hold the captured values steadily.
REQ-021 DRIVE with line_ready[select]=1: transfer done and return to IDLE; if rr_mode=1, rr_ptr increments modulo 2**DEMUX.
REQ-022 line_ready bits for unselected lines are ignored.
REQ-023 Wait counter: cleared on entering DRIVE and increments each DRIVE cycle without line_ready[select].
REQ-024 Timeout: in the TIMEOUT-th DRIVE cycle with no line_ready[select], drop the word, set err=1, increment drop_cnt (saturating), and return to IDLE; rr_ptr still advances if rr_mode=1.
REQ-025 If line_ready[select] is asserted in the timeout cycle, delivery wins and there is no drop.
REQ-026 Latency: out_valid rises one cycle after acceptance; peak throughput is one word per 2 cycles.
REQ-027 rr_ptr wraps from 2**DEMUX-1 to 0.
REQ-028 clear_err=1 together with a drop in the same cycle: the clear wins, giving err=0 and drop_cnt=0.
REQ-029 A change of rr_mode during DRIVE does not affect the word in flight.

Reset
REQ-030 rst_n=0 forces, immediately and asynchronously: state=IDLE, out_valid=0, select=0, out_data=0, rr_ptr=0, wait counter=0, err=0, drop_cnt=0.
REQ-031 A word in flight when reset asserts is discarded and is not counted as a drop.
REQ-032 in_ready=1 from the first clock edge after rst_n deasserts.

Structure
REQ-033 A shared package holds the state encoding (IDLE=0, DRIVE=1) and the drop_cnt width/saturation constant.
REQ-034 The one-hot out_valid is produced by instantiating the existing m_demux with in-flight status as input and select as the select; no other sub-module is used.

Verification
REQ-035 rr_mode=0; send 0xA5 to dest 2 with line_ready=4'b0100 held -> out_valid=4'b0100 one cycle after acceptance, select=2, out_data=0xA5, back in IDLE next cycle.
REQ-036 rr_mode=1; send 5 back-to-back words with all lines ready -> selects 0,1,2,3,0 in order; one accept every 2 cycles.
REQ-037 Hold line_ready=0 with TIMEOUT=16 -> drop after 16 DRIVE cycles, err=1, drop_cnt=1; then clear_err -> err=0, drop_cnt=0.
REQ-038 Assert line_ready[select] exactly in the 16th DRIVE cycle -> word delivered, err stays 0.
REQ-039 Force 300 timeouts -> drop_cnt saturates at 255.
REQ-040 Assert rst_n=0 mid-DRIVE -> out_valid=0 immediately; after release in_ready=1, drop_cnt=0.
